// File: rtl/step_sequencer.sv
// Purpose : holds the instruction register and 2-bit timestep counter for the controller,
//           advancing one timestep per debounced press of the step button.
// Latency : step rises DEBOUNCE_CYCLES+1 clk after the first stable pressed sample at btn_s
//           (btn_s itself lags btn_raw by 2 clk through the synchroniser).
// Backpres: none; the button is a free-running level, so a press that is too short is dropped.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   btn_raw         raw, unsynchronised step button
//   IRin, Clr       controller qualifiers, acted on only in the cycle step=1
//   Bus             shared data bus, loaded into INST on step when IRin=1
//   INST, T         instruction register and timestep, to controller
//   step            registered 1-cycle strobe at each timestep boundary
module step_sequencer #(
    parameter int DATA_W          = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_raw,
    input  logic              IRin,
    input  logic              Clr,
    input  logic [DATA_W-1:0] Bus,
    output logic [DATA_W-1:0] INST,
    output logic [1:0]        T,
    output logic              step
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Raw level of a released button; the synchroniser resets to it so that
    // reset release never looks like a press.
    localparam logic REL_RAW = (BTN_ACTIVE_LOW != 0);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              btn_db_q, btn_db_d;          // debounced level, 1 = pressed
    logic              btn_db_dly_q, btn_db_dly_d;  // debounced level delayed one cycle
    logic              step_q, step_d;
    logic [1:0]        t_q, t_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic              btn_s;

    // Normalised synchronised button: XOR with the released level gives 1 = pressed.
    assign btn_s = sync2_q ^ REL_RAW;

    always_comb begin
        sync1_d      = btn_raw;
        sync2_d      = sync1_q;
        btn_db_dly_d = btn_db_q;
        btn_db_d     = btn_db_q;
        cnt_d        = '0;
        if (btn_s != btn_db_q) begin
            // Only a run of DEBOUNCE_CYCLES differing samples flips the level;
            // any sample equal to btn_db_q falls into the default clear above.
            if (cnt_q == CNT_MAX) begin
                btn_db_d = btn_s;
                cnt_d    = '0;
            end else begin
                cnt_d    = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        step_d = btn_db_q & ~btn_db_dly_q;
        t_d    = t_q;
        inst_d = inst_q;
        if (step_q) begin
            // Clr wins over increment; 3 -> 0 wraps through the 2-bit add.
            t_d = Clr ? 2'd0 : t_q + 2'd1;
            if (IRin) begin
                inst_d = Bus;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= REL_RAW;
            sync2_q      <= REL_RAW;
            cnt_q        <= '0;
            btn_db_q     <= 1'b0;
            btn_db_dly_q <= 1'b0;
            step_q       <= 1'b0;
            t_q          <= 2'd0;
            inst_q       <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            cnt_q        <= cnt_d;
            btn_db_q     <= btn_db_d;
            btn_db_dly_q <= btn_db_dly_d;
            step_q       <= step_d;
            t_q          <= t_d;
            inst_q       <= inst_d;
        end
    end

    assign INST = inst_q;
    assign T    = t_q;
    assign step = step_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Purpose : directed self-checking bench for step_sequencer with DEBOUNCE_CYCLES=8, active-low button.
// Latency : a press driven on btn_raw is seen at btn_s after 2 clk, step follows 9 clk later.
// Backpres: n/a.
module tb_step_sequencer;

    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btn_raw = 1'b1;
    logic          IRin = 1'b0;
    logic          Clr = 1'b0;
    logic [DW-1:0] Bus = '0;
    logic [DW-1:0] INST;
    logic [1:0]    T;
    logic          step;

    int checks = 0;
    int errors = 0;

    step_sequencer #(
        .DATA_W(DW),
        .DEBOUNCE_CYCLES(8),
        .BTN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_raw(btn_raw),
        .IRin(IRin),
        .Clr(Clr),
        .Bus(Bus),
        .INST(INST),
        .T(T),
        .step(step)
    );

    always #5 clk = ~clk;

    // Stimulus helpers only; every comparison lives in the test tasks.
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Holds the button pressed for 'hold' clk, then releases it for 20 clk.
    // first_at is the posedge index (1-based, from the press) of the first step.
    task automatic press_cycles(input int hold, output int nsteps, output int first_at);
        nsteps   = 0;
        first_at = -1;
        @(negedge clk);
        btn_raw = 1'b0;
        for (int i = 1; i <= hold; i++) begin
            @(posedge clk);
            #1;
            if (step) begin
                nsteps++;
                if (first_at < 0) first_at = i;
            end
        end
        @(negedge clk);
        btn_raw = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (step) nsteps++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (INST !== 10'h000 || T !== 2'd0 || step !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: INST=%h T=%0d step=%b, want INST=000 T=0 step=0", INST, T, step);
        end
        rst_n = 1'b1;
        repeat (15) begin
            @(posedge clk);
            #1;
            checks++;
            if (step !== 1'b0) begin
                errors++;
                $display("FAIL reset_release_step: step=%b, want 0", step);
            end
        end
    endtask

    task automatic test_glitch();
        int n, f;
        press_cycles(5, n, f);
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL glitch_steps: got %0d steps, want 0", n);
        end
        checks++;
        if (T !== 2'd0) begin
            errors++;
            $display("FAIL glitch_T: T=%0d, want 0", T);
        end
    endtask

    task automatic test_single_press();
        int n, f;
        Clr = 1'b0;
        press_cycles(100, n, f);
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL held_press_steps: got %0d steps, want 1", n);
        end
        // btn_s rises at posedge 2; step 9 clk later at posedge 11.
        checks++;
        if (f !== 11) begin
            errors++;
            $display("FAIL press_latency: first step at clk %0d, want 11", f);
        end
        checks++;
        if (T !== 2'd1) begin
            errors++;
            $display("FAIL held_press_T: T=%0d, want 1", T);
        end
    endtask

    task automatic test_count_sequence();
        int n, f;
        logic [1:0] exp_t [5];
        exp_t = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        apply_reset();
        Clr  = 1'b0;
        IRin = 1'b0;
        Bus  = 10'h155;
        for (int k = 0; k < 5; k++) begin
            press_cycles(20, n, f);
            checks++;
            if (n !== 1 || T !== exp_t[k]) begin
                errors++;
                $display("FAIL count_seq[%0d]: steps=%0d T=%0d, want steps=1 T=%0d", k, n, T, exp_t[k]);
            end
        end
        checks++;
        if (INST !== 10'h000) begin
            errors++;
            $display("FAIL count_seq_inst: INST=%h, want 000", INST);
        end
    endtask

    task automatic test_ir_load();
        int n, f;
        apply_reset();
        IRin = 1'b1;
        Clr  = 1'b0;
        Bus  = 10'b00_01_10_0010;
        press_cycles(20, n, f);
        checks++;
        if (INST !== 10'h062 || T !== 2'd1) begin
            errors++;
            $display("FAIL ir_load: INST=%h T=%0d, want INST=062 T=1", INST, T);
        end
        IRin = 1'b0;
        Bus  = 10'h2A5;
        press_cycles(20, n, f);
        checks++;
        if (INST !== 10'h062 || T !== 2'd2) begin
            errors++;
            $display("FAIL ir_hold: INST=%h T=%0d, want INST=062 T=2", INST, T);
        end
    endtask

    task automatic test_clr_priority();
        int n, f;
        press_cycles(20, n, f);
        checks++;
        if (T !== 2'd3) begin
            errors++;
            $display("FAIL clr_setup_T: T=%0d, want 3", T);
        end
        Clr  = 1'b1;
        IRin = 1'b1;
        Bus  = 10'h3FF;
        press_cycles(20, n, f);
        checks++;
        if (T !== 2'd0 || INST !== 10'h3FF) begin
            errors++;
            $display("FAIL clr_and_ir: T=%0d INST=%h, want T=0 INST=3FF", T, INST);
        end
        // Clr/IRin with no press must do nothing.
        Bus = 10'h011;
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (T !== 2'd0 || INST !== 10'h3FF) begin
            errors++;
            $display("FAIL clr_no_step: T=%0d INST=%h, want T=0 INST=3FF", T, INST);
        end
        Clr  = 1'b0;
        IRin = 1'b0;
    endtask

    task automatic test_reset_mid_debounce();
        int n, f;
        press_cycles(20, n, f);
        press_cycles(20, n, f);
        checks++;
        if (T !== 2'd2 || INST !== 10'h3FF) begin
            errors++;
            $display("FAIL mid_setup: T=%0d INST=%h, want T=2 INST=3FF", T, INST);
        end
        @(negedge clk);
        btn_raw = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if (dut.cnt_q !== 3'd5) begin
            errors++;
            $display("FAIL mid_cnt: cnt=%0d, want 5", dut.cnt_q);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (INST !== 10'h000 || T !== 2'd0 || step !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async: INST=%h T=%0d step=%b, want 000/0/0", INST, T, step);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        f = -1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (step) begin
                n++;
                if (f < 0) f = i;
            end
        end
        checks++;
        if (n !== 1 || f !== 11) begin
            errors++;
            $display("FAIL mid_restart: steps=%0d first=%0d, want steps=1 first=11", n, f);
        end
        @(negedge clk);
        btn_raw = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (T !== 2'd1 || INST !== 10'h000) begin
            errors++;
            $display("FAIL mid_after: T=%0d INST=%h, want T=1 INST=000", T, INST);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_single_press();
        test_count_sequence();
        test_ir_load();
        test_clr_priority();
        test_reset_mid_debounce();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
